// File: rtl/accum_cpu_pkg.sv
// accum_cpu shared definitions: opcodes, FSM states, ALU operations.
package accum_cpu_pkg;

   localparam logic [3:0] OP_ADDI  = 4'd0;
   localparam logic [3:0] OP_SUBI  = 4'd1;
   localparam logic [3:0] OP_ANDI  = 4'd2;
   localparam logic [3:0] OP_ORI   = 4'd3;
   localparam logic [3:0] OP_XORI  = 4'd4;
   localparam logic [3:0] OP_LOAD  = 4'd5;
   localparam logic [3:0] OP_STORE = 4'd6;
   localparam logic [3:0] OP_JMP   = 4'd7;
   localparam logic [3:0] OP_JZ    = 4'd8;
   localparam logic [3:0] OP_JC    = 4'd9;
   localparam logic [3:0] OP_ADDM  = 4'd10;
   localparam logic [3:0] OP_SUBM  = 4'd11;
   localparam logic [3:0] OP_HALT  = 4'd15;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_PASS
   } alu_op_t;

endpackage

// File: rtl/accum_cpu_if.sv
// accum_cpu bus: instruction fetch handshake, data store port, status.
interface accum_cpu_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 8
);
   logic              instr_req;
   logic [PC_W-1:0]   instr_addr;
   logic              instr_valid;
   logic [ADDR_W+3:0] instr_data;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] acc_out;
   logic [1:0]        flags_out;
   logic              halted;

   modport master (
      output instr_req, instr_addr,
      input  instr_valid, instr_data,
      output wr_valid, wr_addr, wr_data,
      output acc_out, flags_out, halted
   );

   modport slave (
      input  instr_req, instr_addr,
      output instr_valid, instr_data,
      input  wr_valid, wr_addr, wr_data,
      input  acc_out, flags_out, halted
   );
endinterface

// File: rtl/accum_alu.sv
// accum_cpu ALU: modular add/sub with carry/borrow, logic ops, pass-through.
module accum_alu
   import accum_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         ALU_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
         // the extra top bit of a widened subtract is the borrow
         ALU_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_PASS: result = b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/accum_cpu.sv
// accum_cpu: two-phase (fetch/execute) accumulator CPU with
// internal data memory and a single-cycle store pulse.
module accum_cpu
   import accum_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 8
) (
   input logic         clk,
   input logic         rst,
   accum_cpu_if.master bus
);

   localparam int DEPTH = 1 << ADDR_W;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              c_flag, z_flag;
   logic [ADDR_W+3:0] ir;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] imm, mem_rd, alu_b, alu_res;
   logic              alu_c;
   alu_op_t           alu_op;
   logic              acc_wr, c_wr, is_store, take;
   logic              fetch_done, in_exec;

   assign opcode     = ir[ADDR_W+3:ADDR_W];
   assign operand    = ir[ADDR_W-1:0];
   assign imm        = DATA_W'(operand);
   assign mem_rd     = mem[operand];
   assign fetch_done = (state == ST_FETCH) && bus.instr_valid;
   assign in_exec    = (state == ST_EXEC);

   accum_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op),
      .a      (acc),
      .b      (alu_b),
      .result (alu_res),
      .carry  (alu_c)
   );

   always_comb begin
      alu_op   = ALU_ADD;
      alu_b    = imm;
      acc_wr   = 1'b0;
      c_wr     = 1'b0;
      is_store = 1'b0;
      take     = 1'b0;
      case (opcode)
         OP_ADDI:  begin acc_wr = 1'b1; c_wr = 1'b1; end
         OP_SUBI:  begin
            alu_op = ALU_SUB; acc_wr = 1'b1; c_wr = 1'b1;
         end
         OP_ANDI:  begin alu_op = ALU_AND; acc_wr = 1'b1; end
         OP_ORI:   begin alu_op = ALU_OR;  acc_wr = 1'b1; end
         OP_XORI:  begin alu_op = ALU_XOR; acc_wr = 1'b1; end
         OP_LOAD:  begin
            alu_op = ALU_PASS; alu_b = mem_rd; acc_wr = 1'b1;
         end
         OP_STORE: is_store = 1'b1;
         OP_JMP:   take = 1'b1;
         OP_JZ:    take = z_flag;
         OP_JC:    take = c_flag;
         OP_ADDM:  begin alu_b = mem_rd; acc_wr = 1'b1; c_wr = 1'b1; end
         OP_SUBM:  begin
            alu_op = ALU_SUB; alu_b = mem_rd;
            acc_wr = 1'b1; c_wr = 1'b1;
         end
         default:  ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         ST_FETCH: if (bus.instr_valid) state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (opcode == OP_HALT) begin
               state_nxt = ST_HALT;
            end else begin
               state_nxt = ST_FETCH;
               pc_nxt = take ? PC_W'(operand) : pc + PC_W'(1);
            end
         end
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_FETCH;
         pc     <= '0;
         acc    <= '0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
         ir     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (fetch_done) ir <= bus.instr_data;
         if (in_exec) begin
            if (acc_wr) begin
               acc    <= alu_res;
               z_flag <= (alu_res == '0);
            end
            if (c_wr) c_flag <= alu_c;
            if (is_store) mem[operand] <= acc;
         end
      end
   end

   // request is masked during reset so the bus sees no fetch while rst is high
   assign bus.instr_req  = (state == ST_FETCH) && !rst;
   assign bus.instr_addr = pc;
   assign bus.wr_valid   = in_exec && is_store;
   assign bus.wr_addr    = bus.wr_valid ? operand : '0;
   assign bus.wr_data    = bus.wr_valid ? acc : '0;
   assign bus.acc_out    = acc;
   assign bus.flags_out  = {c_flag, z_flag};
   assign bus.halted     = (state == ST_HALT);

endmodule

// File: tb/tb_accum_cpu.sv
// accum_cpu bench: directed and random programs against an
// instruction-level model; a monitor scores completions and stores.
module tb_accum_cpu;

   logic clk = 1'b0;
   logic rst = 1'b1;

   accum_cpu_if #(.DATA_W(8), .ADDR_W(5), .PC_W(8)) bus ();

   accum_cpu #(.DATA_W(8), .ADDR_W(5), .PC_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int acc;
      int flags;
      int pc;
      bit halt;
   } exp_t;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];

   int n_chk = 0;
   int n_err = 0;

   int m_acc, m_pc;
   bit m_c, m_z;
   int m_mem[32];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_acc = 0;
      m_pc  = 0;
      m_c   = 1'b0;
      m_z   = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
   endfunction

   function automatic void model_step(input int op, input int opd);
      int s;
      int b;
      bit tk;
      tk = 1'b0;
      b  = (op == 10 || op == 11) ? m_mem[opd] : opd;
      case (op)
         0, 10: begin
            s = m_acc + b;
            m_c = (s > 255);
            m_acc = s % 256;
            m_z = (m_acc == 0);
         end
         1, 11: begin
            m_c = (m_acc < b);
            m_acc = (m_acc - b + 256) % 256;
            m_z = (m_acc == 0);
         end
         2: begin m_acc = m_acc & b; m_z = (m_acc == 0); end
         3: begin m_acc = m_acc | b; m_z = (m_acc == 0); end
         4: begin m_acc = m_acc ^ b; m_z = (m_acc == 0); end
         5: begin m_acc = m_mem[opd]; m_z = (m_acc == 0); end
         6: begin
            m_mem[opd] = m_acc;
            wr_q.push_back('{opd, m_acc});
         end
         7: tk = 1'b1;
         8: tk = m_z;
         9: tk = m_c;
         default: ;
      endcase
      if (op != 15) m_pc = tk ? opd : (m_pc + 1) % 256;
      exp_q.push_back('{m_acc, int'(m_c) * 2 + int'(m_z),
                        m_pc, op == 15});
   endfunction

   bit prev_req  = 1'b1;
   bit prev_halt = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      if (rst) begin
         prev_req  = 1'b1;
         prev_halt = 1'b0;
      end else begin
         if (bus.wr_valid) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_wr", 32'(bus.wr_addr), 32'hFFFF);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", 32'(bus.wr_addr), 32'(w.addr));
               chk("wr_data", 32'(bus.wr_data), 32'(w.data));
            end
         end
         if ((bus.instr_req && !prev_req) ||
             (bus.halted && !prev_halt)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(bus.acc_out), 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("acc", 32'(bus.acc_out), 32'(e.acc));
               chk("flags", 32'(bus.flags_out), 32'(e.flags));
               chk("halted", 32'(bus.halted), 32'(e.halt));
               if (!e.halt)
                  chk("pc", 32'(bus.instr_addr), 32'(e.pc));
               else
                  chk("halt_req", 32'(bus.instr_req), 0);
            end
         end
         prev_req  = bus.instr_req;
         prev_halt = bus.halted;
      end
   end

   task automatic do_reset();
      #1 rst = 1'b1;
      bus.instr_valid = 1'b0;
      exp_q.delete();
      wr_q.delete();
      model_reset();
      #1;
      chk("rst_req", 32'(bus.instr_req), 0);
      chk("rst_wr_valid", 32'(bus.wr_valid), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_acc", 32'(bus.acc_out), 0);
      chk("rst_flags", 32'(bus.flags_out), 0);
      chk("rst_addr", 32'(bus.instr_addr), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req", 32'(bus.instr_req), 1);
      chk("post_rst_addr", 32'(bus.instr_addr), 0);
   endtask

   task automatic run_instr(input int op, input int opd, input int gap,
                            output int cycles);
      int cyc;
      logic [7:0] a0;
      cycles = 0;
      chk("fetch_req", 32'(bus.instr_req), 1);
      a0 = bus.instr_addr;
      for (int i = 0; i < gap; i++) begin
         bus.instr_valid = 1'b0;
         bus.instr_data  = 9'($urandom);
         @(negedge clk);
         cycles++;
         chk("stall_req", 32'(bus.instr_req), 1);
         chk("stall_addr", 32'(bus.instr_addr), 32'(a0));
      end
      bus.instr_valid = 1'b1;
      bus.instr_data  = {4'(op), 5'(opd)};
      model_step(op, opd);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.instr_req || bus.halted || cyc >= 8) break;
         bus.instr_valid = 1'($urandom);
         bus.instr_data  = 9'($urandom);
      end
      bus.instr_valid = 1'b0;
      chk("instr_latency", 32'(cyc), 2);
      cycles += cyc;
   endtask

   task automatic run(input int op, input int opd);
      int c;
      run_instr(op, opd, 0, c);
   endtask

   initial begin
      int c, tot;
      logic [7:0] a0;
      bus.instr_valid = 1'b0;
      bus.instr_data  = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      tot = 0;
      run_instr(0, 3, 0, c); tot += c;
      run_instr(0, 5, 0, c); tot += c;
      run_instr(1, 8, 0, c); tot += c;
      chk("seq3_cycles", 32'(tot), 6);
      chk("seq3_acc", 32'(bus.acc_out), 0);
      chk("seq3_flags", 32'(bus.flags_out), 2'b01);

      run(1, 1);
      run(0, 1);
      chk("wrap_add_acc", 32'(bus.acc_out), 0);
      chk("wrap_add_flags", 32'(bus.flags_out), 2'b11);
      run(1, 1);
      chk("borrow_acc", 32'(bus.acc_out), 8'hFF);
      chk("borrow_flags", 32'(bus.flags_out), 2'b10);

      run(2, 0);
      run(0, 31);
      run(0, 11);
      run(6, 7);
      run(4, 10);
      run(5, 7);
      chk("store_load_acc", 32'(bus.acc_out), 8'h2A);

      a0 = bus.instr_addr;
      run(8, 16);
      chk("jz_not_taken", 32'(bus.instr_addr), 32'(a0 + 8'd1));
      run(2, 0);
      run(8, 16);
      chk("jz_taken", 32'(bus.instr_addr), 32'h10);
      while (m_pc != 255) run(12, 0);
      run(13, 0);
      chk("pc_wrap", 32'(bus.instr_addr), 0);

      run_instr(0, 1, 3, c);
      chk("stall_cycles", 32'(c), 5);

      run(2, 0);
      run(0, 9);
      bus.instr_valid = 1'b1;
      bus.instr_data  = {4'd6, 5'd3};
      model_step(6, 3);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      do_reset();
      run(5, 3);
      chk("abort_no_write", 32'(bus.acc_out), 0);

      run(0, 4);
      run(15, 0);
      for (int i = 0; i < 10; i++) begin
         bus.instr_valid = 1'b1;
         bus.instr_data  = 9'($urandom);
         @(negedge clk);
         chk("halt_hold", 32'(bus.halted), 1);
         chk("halt_no_req", 32'(bus.instr_req), 0);
      end
      bus.instr_valid = 1'b0;
      do_reset();
      chk("halt_rst_acc", 32'(bus.acc_out), 0);

      for (int i = 0; i < 300; i++) begin
         int g;
         g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         run_instr($urandom_range(0, 14), $urandom_range(0, 31), g, c);
      end
      run(15, 0);
      @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 0);
      chk("wr_q_empty", 32'(wr_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/accum_cpu.md
ACCUM_CPU -- requirements
Module: accum_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8: accumulator, ALU and data-memory word width.
REQ-002 SHALL have parameter ADDR_W, default 5: operand field width; data memory holds 2**ADDR_W words.
REQ-003 SHALL have parameter PC_W, default 8: program counter and instruction address width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port instr_req, output, 1: fetch request.
REQ-007 SHALL have port instr_addr, output, PC_W: fetch address; equals PC.
REQ-008 SHALL have port instr_valid, input, 1: instr_data valid; completes a fetch when sampled high with instr_req high.
REQ-009 SHALL have port instr_data, input, 4+ADDR_W: opcode in [ADDR_W+3:ADDR_W], operand in [ADDR_W-1:0].
REQ-010 SHALL have port wr_valid, output, 1: one-cycle pulse per executed STORE.
REQ-011 SHALL have port wr_addr, output, ADDR_W: STORE address.
REQ-012 SHALL have port wr_data, output, DATA_W: STORE data.
REQ-013 SHALL have port acc_out, output, DATA_W: accumulator value.
REQ-014 SHALL have port flags_out, output, 2: {C, Z}.
REQ-015 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-016 SHALL implement FSM states FETCH, EXEC, HALT: FETCH->EXEC on instr_req&&instr_valid, latching instr_data; EXEC->FETCH, or EXEC->HALT for opcode HALT; HALT is exited only by rst.
REQ-017 SHALL drive instr_req high in FETCH only and hold instr_addr stable until the fetch completes; instr_valid outside FETCH is ignored.
REQ-018 SHALL take at least two cycles per instruction; each wait cycle with instr_valid low adds exactly one cycle.
REQ-019 SHALL decode opcodes: 0 ADDI, 1 SUBI, 2 ANDI, 3 ORI, 4 XORI, 5 LOAD, 6 STORE, 7 JMP, 8 JZ, 9 JC, 10 ADDM, 11 SUBM, 15 HALT; 12-14 are NOP.
REQ-020 SHALL zero-extend the operand to DATA_W for immediates and to PC_W for jump targets.
REQ-021 SHALL compute ALU results modulo 2**DATA_W; C = carry-out for ADD*, C = borrow for SUB*, C unchanged for logic ops.
REQ-022 SHALL set Z = (new accumulator == 0) on every ALU op and LOAD; STORE, jumps, NOP and HALT leave both flags unchanged.
REQ-023 SHALL, for LOAD, set ACC = mem[operand]; for ADDM/SUBM, use mem[operand] as the ALU B operand.
REQ-024 SHALL, for STORE, write mem[operand] = ACC in EXEC and pulse wr_valid in that same cycle with wr_addr/wr_data.
REQ-025 SHALL set PC = target for JMP, for JZ when Z=1 and for JC when C=1; otherwise PC = PC+1, wrapping from 2**PC_W-1 to 0.
REQ-026 SHALL make a STORE visible to a LOAD/ADDM in the immediately following instruction.
REQ-027 SHALL leave PC unchanged on HALT, with halted high from the cycle after HALT's EXEC.

Reset
REQ-028 SHALL, on rst, asynchronously force FETCH, PC=0, ACC=0, flags=0, all data memory words to 0, and instr_req, wr_valid, wr_addr, wr_data, halted to 0.
REQ-029 SHALL abandon an in-flight fetch or execute on rst mid-operation, with no memory write and no wr_valid pulse.
REQ-030 SHALL re-issue a fetch at address 0 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL take opcode constants and the FSM state encoding from a shared package, accum_cpu_pkg.
REQ-032 SHALL instantiate one combinational sub-module, accum_alu, parameterised by DATA_W, returning result and carry/borrow.

Verification
REQ-033 SHALL test ADDI 3, ADDI 5, SUBI 8 with instr_valid always high: ACC 3, 8, 0; Z=1 after SUBI; 6 cycles total.
REQ-034 SHALL test ACC=0xFF then ADDI 1: ACC=0x00, C=1, Z=1; a following SUBI 1 gives ACC=0xFF, C=1 (borrow).
REQ-035 SHALL test STORE 7 with ACC=0x2A, then XORI 0x0A, then LOAD 7: wr_valid pulse with addr 7 / data 0x2A, ACC ends 0x2A.
REQ-036 SHALL test JZ 0x10 with Z=0 -> next instr_addr=PC+1, and with Z=1 -> instr_addr=0x10; PC=0xFF plus NOP wraps to 0x00.
REQ-037 SHALL test instr_valid held low 3 cycles: instr_req and instr_addr stable, instruction completes 3 cycles late.
REQ-038 SHALL test HALT: halted=1 and instr_req=0 indefinitely; rst asserted mid-HALT then released gives instr_addr=0 with ACC=0.
